// File: rtl/tri_128x34_4w_wr_ctl.sv
// Requester-side controller for the 128x34 4-way 1r1w array: write queue, array clear, read stall and response pipe.
// Optional parity generation/checking is enabled by defining TRI_WR_CTL_PARITY_EN.
module tri_128x34_4w_wr_ctl #(
  parameter int addressable_ports = 128,
  parameter int addressbus_width  = 7,
  parameter int port_bitwidth     = 34,
  parameter int ways              = 4,
  parameter int wq_depth          = 4
) (
  input  logic [1:0]                      nclk,
  input  logic                            init_req,
  output logic                            init_done,
  input  logic                            req_val,
  output logic                            req_rdy,
  input  logic [addressbus_width-1:0]     req_addr,
  input  logic [ways-1:0]                 req_way,
  input  logic [port_bitwidth-1:0]        req_data,
  input  logic                            rd_req_val,
  output logic                            rd_req_rdy,
  input  logic [addressbus_width-1:0]     rd_req_addr,
  output logic                            rsp_val,
  output logic [port_bitwidth*ways-1:0]   rsp_data,
  output logic [ways-1:0]                 rsp_par_err,
  output logic                            wr_act,
  output logic [ways-1:0]                 wr_way,
  output logic [addressbus_width-1:0]     wr_addr,
  output logic [port_bitwidth*ways-1:0]   data_in,
  output logic                            rd_act,
  output logic [addressbus_width-1:0]     rd_addr,
  input  logic [port_bitwidth*ways-1:0]   data_out,
  output logic [1:0]                      dbg_state
);

  localparam int QW = $clog2(wq_depth);
  localparam int PW = port_bitwidth;
  localparam logic [QW:0] WQ_CNT = (QW+1)'(wq_depth);

  typedef enum logic [1:0] {S_INIT = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  logic rst;
  assign rst = nclk[1];

  state_t                     state_q, state_d;
  logic [addressbus_width-1:0] icnt_q, icnt_d;
  logic [addressbus_width-1:0] fa_q [wq_depth];
  logic [ways-1:0]             fw_q [wq_depth];
  logic [PW-1:0]               fd_q [wq_depth];
  logic [wq_depth-1:0]         vld_q;
  logic [QW-1:0]               wp_q, rp_q;
  logic [QW:0]                 cnt_q;
  logic                        rv1_q, rv2_q;
  logic                        push, pop, hit, fifo_empty, run;
  logic [PW-1:0]               enq_data;

`ifdef TRI_WR_CTL_PARITY_EN
  assign enq_data = {^req_data[PW-2:0], req_data[PW-2:0]};
`else
  assign enq_data = req_data;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready never depends on the same-cycle valid of its own channel.
  assign run        = (state_q == S_RUN);
  assign fifo_empty = (cnt_q == '0);
  assign req_rdy    = run && (cnt_q != WQ_CNT);
  assign push       = req_val && req_rdy;
  assign pop        = !fifo_empty && (state_q != S_INIT);
  assign init_done  = run;
  assign dbg_state  = state_q;

  // Any queued entry (head included) to the read row stalls the read; a same-cycle enqueue does not.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < wq_depth; i++) begin
      if (vld_q[i] && (fa_q[i] == rd_req_addr)) hit = 1'b1;
    end
  end

  assign rd_req_rdy = run && !hit;
  assign rd_act     = rd_req_val && rd_req_rdy;
  assign rd_addr    = rd_req_addr;
  assign rsp_val    = rv2_q;
  assign rsp_data   = data_out;

`ifdef TRI_WR_CTL_PARITY_EN
  always_comb begin
    rsp_par_err = '0;
    for (int k = 0; k < ways; k++) rsp_par_err[k] = rv2_q & (^data_out[k*PW +: PW]);
  end
`else
  assign rsp_par_err = '0;
`endif

  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    case (state_q)
      S_INIT: begin
        icnt_d = icnt_q + 1'b1;
        if (icnt_q == '1) state_d = S_RUN;
      end
      S_RUN: begin
        if (init_req) begin
          state_d = fifo_empty ? S_INIT : S_DRAIN;
          icnt_d  = '0;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_d = S_INIT;
          icnt_d  = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    wr_act  = 1'b0;
    wr_way  = '0;
    wr_addr = '0;
    data_in = '0;
    if (state_q == S_INIT) begin
      wr_act  = 1'b1;
      wr_way  = '1;
      wr_addr = icnt_q;
    end else if (pop) begin
      wr_act  = 1'b1;
      wr_way  = fw_q[rp_q];
      wr_addr = fa_q[rp_q];
      data_in = {ways{fd_q[rp_q]}};
    end
  end

  always_ff @(posedge nclk[0]) begin
    if (rst) begin
      state_q <= S_INIT;
      icnt_q  <= '0;
      vld_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      rv1_q   <= 1'b0;
      rv2_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      rv1_q   <= rd_act;
      rv2_q   <= rv1_q;
      if (pop) begin
        vld_q[rp_q] <= 1'b0;
        rp_q        <= rp_q + 1'b1;
      end
      if (push) begin
        vld_q[wp_q] <= 1'b1;
        wp_q        <= wp_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge nclk[0]) begin
    if (push) begin
      fa_q[wp_q] <= req_addr;
      fw_q[wp_q] <= req_way;
      fd_q[wp_q] <= enq_data;
    end
  end

endmodule
